// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive path.
//   MIN_PRESCALE   : smallest usable oversample ratio (three samples need room)
//   MIN_DATA_BITS  : smallest legal data field width
//   FRAME_OVERHEAD : start bit plus one stop bit
//   maj3           : 2-of-3 majority vote
package uart_rx_pkg;

  localparam int MIN_PRESCALE   = 4;
  localparam int MIN_DATA_BITS  = 5;
  localparam int FRAME_OVERHEAD = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer_if.sv
// Bundle between the RX FSM side (master) and the bit timer (slave).
//   master drives : enable, prescale, data_bits, par_en, stop2, rx_in
//   slave drives  : edge_cnt, bit_cnt, sampled_bit, sample_valid,
//                   bit_done, frame_done
interface uart_rx_bit_timer_if #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
);

  logic                  enable;
  logic [PRESCALE_W-1:0] prescale;
  logic [BIT_CNT_W-1:0]  data_bits;
  logic                  par_en;
  logic                  stop2;
  logic                  rx_in;

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  sampled_bit;
  logic                  sample_valid;
  logic                  bit_done;
  logic                  frame_done;

  modport master (
    output enable, prescale, data_bits, par_en, stop2, rx_in,
    input  edge_cnt, bit_cnt, sampled_bit, sample_valid, bit_done, frame_done
  );

  modport slave (
    input  enable, prescale, data_bits, par_en, stop2, rx_in,
    output edge_cnt, bit_cnt, sampled_bit, sample_valid, bit_done, frame_done
  );

endinterface

// File: rtl/uart_rx_vote_sampler.sv
// Three-point mid-bit sampler with majority vote.
//   clk, rst      : clock, async active-low reset
//   enable_i      : low clears the valid strobe; sampled value is held
//   edge_cnt_i    : current oversample index within the bit
//   mid_i         : centre index of the bit (prescale >> 1)
//   rx_in_i       : synchronised serial line
//   sampled_bit_o : majority of the samples at mid-1, mid, mid+1
//   sample_valid_o: one-cycle strobe, sampled_bit_o just updated
module uart_rx_vote_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic [PRESCALE_W-1:0] edge_cnt_i,
  input  logic [PRESCALE_W-1:0] mid_i,
  input  logic                  rx_in_i,
  output logic                  sampled_bit_o,
  output logic                  sample_valid_o
);

  logic s0_q, s0_d;
  logic s1_q, s1_d;
  logic bit_q, bit_d;
  logic valid_q, valid_d;

  always_comb begin
    s0_d    = s0_q;
    s1_d    = s1_q;
    bit_d   = bit_q;
    valid_d = 1'b0;
    if (enable_i) begin
      if (edge_cnt_i == mid_i - PRESCALE_W'(1)) s0_d = rx_in_i;
      if (edge_cnt_i == mid_i)                  s1_d = rx_in_i;
      // Third sample is taken live rather than registered.
      if (edge_cnt_i == mid_i + PRESCALE_W'(1)) begin
        bit_d   = maj3(s0_q, s1_q, rx_in_i);
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
    end
  end

  assign sampled_bit_o  = bit_q;
  assign sample_valid_o = valid_q;

endmodule

// File: rtl/uart_rx_bit_timer.sv
// Oversampling bit/frame timer for the UART receiver.
//   clk, rst : clock, async active-low reset
//   bus      : slave side of uart_rx_bit_timer_if
//              config (prescale, data_bits, par_en, stop2) is latched while
//              enable is low and frozen while a frame is being timed;
//              edge_cnt/bit_cnt count position, bit_done/frame_done strobe
//              at bit and frame ends, the vote sampler supplies sampled_bit.
module uart_rx_bit_timer
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W    = 6,
  parameter int BIT_CNT_W     = 4,
  parameter int MAX_DATA_BITS = 8
) (
  input logic                clk,
  input logic                rst,
  uart_rx_bit_timer_if.slave bus
);

  localparam logic [PRESCALE_W-1:0] MIN_P = PRESCALE_W'(MIN_PRESCALE);
  localparam logic [PRESCALE_W-1:0] RST_P = PRESCALE_W'(8);
  localparam logic [BIT_CNT_W-1:0]  MIN_DB = BIT_CNT_W'(MIN_DATA_BITS);
  localparam logic [BIT_CNT_W-1:0]  MAX_DB = BIT_CNT_W'(MAX_DATA_BITS);
  localparam logic [BIT_CNT_W-1:0]  RST_DB = BIT_CNT_W'(8);

  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [BIT_CNT_W-1:0]  data_bits_q, data_bits_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;

  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic                  bit_done_q, bit_done_d;
  logic                  frame_done_q, frame_done_d;

  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] last_edge;
  logic [BIT_CNT_W-1:0]  frame_bits;
  logic [BIT_CNT_W-1:0]  last_bit;

  logic sampled_bit_w;
  logic sample_valid_w;

  // Config follows the inputs only while idle, so a frame never sees a
  // period or length change part way through.
  always_comb begin
    prescale_d  = prescale_q;
    data_bits_d = data_bits_q;
    par_en_d    = par_en_q;
    stop2_d     = stop2_q;
    if (!bus.enable) begin
      prescale_d  = (bus.prescale < MIN_P) ? MIN_P : bus.prescale;
      data_bits_d = (bus.data_bits < MIN_DB) ? MIN_DB :
                    (bus.data_bits > MAX_DB) ? MAX_DB : bus.data_bits;
      par_en_d    = bus.par_en;
      stop2_d     = bus.stop2;
    end
  end

  assign mid        = prescale_q >> 1;
  assign last_edge  = prescale_q - PRESCALE_W'(1);
  assign frame_bits = BIT_CNT_W'(FRAME_OVERHEAD) + data_bits_q
                    + BIT_CNT_W'(par_en_q) + BIT_CNT_W'(stop2_q);
  assign last_bit   = frame_bits - BIT_CNT_W'(1);

  always_comb begin
    edge_d       = edge_q;
    bit_d        = bit_q;
    bit_done_d   = 1'b0;
    frame_done_d = 1'b0;
    if (!bus.enable) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (edge_q == last_edge) begin
      edge_d     = '0;
      bit_done_d = 1'b1;
      if (bit_q == last_bit) begin
        bit_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        bit_d = bit_q + BIT_CNT_W'(1);
      end
    end else begin
      edge_d = edge_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale_q   <= RST_P;
      data_bits_q  <= RST_DB;
      par_en_q     <= 1'b0;
      stop2_q      <= 1'b0;
      edge_q       <= '0;
      bit_q        <= '0;
      bit_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      prescale_q   <= prescale_d;
      data_bits_q  <= data_bits_d;
      par_en_q     <= par_en_d;
      stop2_q      <= stop2_d;
      edge_q       <= edge_d;
      bit_q        <= bit_d;
      bit_done_q   <= bit_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  uart_rx_vote_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (bus.enable),
    .edge_cnt_i     (edge_q),
    .mid_i          (mid),
    .rx_in_i        (bus.rx_in),
    .sampled_bit_o  (sampled_bit_w),
    .sample_valid_o (sample_valid_w)
  );

  assign bus.edge_cnt     = edge_q;
  assign bus.bit_cnt      = bit_q;
  assign bus.bit_done     = bit_done_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.sampled_bit  = sampled_bit_w;
  assign bus.sample_valid = sample_valid_w;

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Self-checking bench for uart_rx_bit_timer: position-based reference
// model compared every cycle, plus directed scenarios with literal results.
module tb_uart_rx_bit_timer;

  localparam int PW  = 6;
  localparam int BW  = 4;
  localparam int MDB = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_rx_bit_timer_if #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) bus ();

  uart_rx_bit_timer #(
    .PRESCALE_W    (PW),
    .BIT_CNT_W     (BW),
    .MAX_DATA_BITS (MDB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: k = number of enabled edges since enable rose.
  int cP = 8, cDB = 8, cPar = 0, cS2 = 0;
  int k = 0;
  bit exp_sb = 1'b0;
  bit hist[$];

  function automatic int clamp_p(input int p);
    return (p < 4) ? 4 : p;
  endfunction

  function automatic int clamp_db(input int d);
    return (d < 5) ? 5 : ((d > MDB) ? MDB : d);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      k = 0; cP = 8; cDB = 8; cPar = 0; cS2 = 0; exp_sb = 1'b0;
      hist.delete();
    end else if (bus.enable !== 1'b1) begin
      k = 0;
      hist.delete();
      cP   = clamp_p(int'(bus.prescale));
      cDB  = clamp_db(int'(bus.data_bits));
      cPar = int'(bus.par_en);
      cS2  = int'(bus.stop2);
    end else begin
      int b, m;
      hist.push_back(bus.rx_in);
      k++;
      m = cP / 2;
      if (((k - 1) % cP) == m + 1) begin
        b = (k - 1) - ((k - 1) % cP);
        exp_sb = (int'(hist[b + m - 1]) + int'(hist[b + m]) + int'(hist[k - 1])) >= 2;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      int fb, m;
      fb = 2 + cDB + cPar + cS2;
      m  = cP / 2;
      chk("edge_cnt", 32'(bus.edge_cnt), k % cP);
      chk("bit_cnt", 32'(bus.bit_cnt), (k / cP) % fb);
      chk("bit_done", 32'(bus.bit_done), (k > 0 && k % cP == 0) ? 1 : 0);
      chk("frame_done", 32'(bus.frame_done), (k > 0 && k % (cP * fb) == 0) ? 1 : 0);
      chk("sample_valid", 32'(bus.sample_valid), (k > 0 && (k - 1) % cP == m + 1) ? 1 : 0);
      chk("sampled_bit", 32'(bus.sampled_bit), int'(exp_sb));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cfg(input int p, input int db, input bit par, input bit s2);
    bus.prescale  = PW'(p);
    bus.data_bits = BW'(db);
    bus.par_en    = par;
    bus.stop2     = s2;
  endtask

  task automatic measure(input int limit, output int f_bd, output int f_sv,
                         output int f_fd, output int n_bd, output int max_bit);
    f_bd = -1; f_sv = -1; f_fd = -1; n_bd = 0; max_bit = 0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk);
      #1;
      if (bus.bit_done === 1'b1) begin
        n_bd++;
        if (f_bd < 0) f_bd = i;
      end
      if (bus.sample_valid === 1'b1 && f_sv < 0) f_sv = i;
      if (int'(bus.bit_cnt) > max_bit) max_bit = int'(bus.bit_cnt);
      if (bus.frame_done === 1'b1) begin
        f_fd = i;
        break;
      end
    end
  endtask

  initial begin
    int f_bd, f_sv, f_fd, n_bd, max_bit, cnt;
    bit lit_sb[4];
    lit_sb[0] = 1'b1; lit_sb[1] = 1'b0; lit_sb[2] = 1'b0; lit_sb[3] = 1'b1;

    bus.enable = 1'b0;
    bus.rx_in  = 1'b1;
    set_cfg(8, 8, 1'b0, 1'b0);

    // Reset state
    tick(2);
    chk("rst_edge_cnt", 32'(bus.edge_cnt), 0);
    chk("rst_bit_cnt", 32'(bus.bit_cnt), 0);
    chk("rst_sampled_bit", 32'(bus.sampled_bit), 0);
    chk("rst_bit_done", 32'(bus.bit_done), 0);
    chk("rst_frame_done", 32'(bus.frame_done), 0);
    rst = 1'b1;
    tick(2);

    // 8N1 at prescale 8
    bus.enable = 1'b1;
    measure(200, f_bd, f_sv, f_fd, n_bd, max_bit);
    chk("8n1_first_sv", 32'(f_sv), 6);
    chk("8n1_first_bd", 32'(f_bd), 8);
    chk("8n1_frame_len", 32'(f_fd), 80);
    chk("8n1_bit_dones", 32'(n_bd), 10);
    chk("8n1_bitcnt_wrap", 32'(bus.bit_cnt), 0);
    tick(20);  // back-to-back frame continues under the model
    bus.enable = 1'b0;
    tick(2);

    // Prescale 16, 7 data bits, parity, two stop bits
    set_cfg(16, 7, 1'b1, 1'b1);
    tick(1);
    bus.enable = 1'b1;
    measure(400, f_bd, f_sv, f_fd, n_bd, max_bit);
    chk("7e2_frame_len", 32'(f_fd), 176);
    chk("7e2_max_bit", 32'(max_bit), 10);
    chk("7e2_bit_dones", 32'(n_bd), 11);
    bus.enable = 1'b0;
    tick(2);

    // Majority vote at prescale 16, samples at edges 7, 8, 9
    set_cfg(16, 8, 1'b0, 1'b0);
    tick(1);
    bus.enable = 1'b1;
    for (int j = 0; j < 64; j++) begin
      int b, e;
      b = j / 16;
      e = j % 16;
      case (b)
        0: bus.rx_in = (e == 7 || e == 9);
        1: bus.rx_in = !(e == 7 || e == 8);
        2: bus.rx_in = (e == 8);
        default: bus.rx_in = (e != 8);
      endcase
      tick(1);
      if (e == 9) begin
        chk("vote_valid", 32'(bus.sample_valid), 1);
        chk($sformatf("vote_bit%0d", b), 32'(bus.sampled_bit), int'(lit_sb[b]));
      end
    end
    bus.enable = 1'b0;
    bus.rx_in  = 1'b1;
    tick(2);

    // Clamping: prescale 2 -> 4, data_bits 12 -> 8
    set_cfg(2, 12, 1'b0, 1'b0);
    tick(1);
    bus.enable = 1'b1;
    measure(200, f_bd, f_sv, f_fd, n_bd, max_bit);
    chk("clamp_first_bd", 32'(f_bd), 4);
    chk("clamp_first_sv", 32'(f_sv), 4);
    chk("clamp_frame_len", 32'(f_fd), 40);
    bus.enable = 1'b0;
    tick(2);

    // Config freeze: prescale change ignored until enable drops
    set_cfg(8, 8, 1'b0, 1'b0);
    tick(1);
    bus.enable = 1'b1;
    tick(10);
    bus.prescale = PW'(12);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (bus.bit_done === 1'b1) cnt++;
    end
    chk("freeze_bd_count", 32'(cnt), 4);
    bus.enable = 1'b0;
    tick(2);
    bus.enable = 1'b1;
    measure(30, f_bd, f_sv, f_fd, n_bd, max_bit);
    chk("freeze_next_period", 32'(f_bd), 12);
    bus.enable = 1'b0;
    tick(2);

    // Abort at bit_cnt 4, edge_cnt 3
    set_cfg(8, 8, 1'b0, 1'b0);
    tick(1);
    bus.enable = 1'b1;
    tick(35);
    chk("abort_pre_bit", 32'(bus.bit_cnt), 4);
    chk("abort_pre_edge", 32'(bus.edge_cnt), 3);
    bus.enable = 1'b0;
    tick(1);
    chk("abort_edge", 32'(bus.edge_cnt), 0);
    chk("abort_bit", 32'(bus.bit_cnt), 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      cnt += int'(bus.bit_done) + int'(bus.frame_done) + int'(bus.sample_valid);
    end
    chk("abort_no_strobes", 32'(cnt), 0);

    // Async reset mid-frame, config returns to prescale 8
    set_cfg(12, 8, 1'b0, 1'b0);
    tick(1);
    bus.enable = 1'b1;
    tick(30);
    chk("prerst_sampled", 32'(bus.sampled_bit), 1);
    rst = 1'b0;
    #1;
    chk("arst_edge_cnt", 32'(bus.edge_cnt), 0);
    chk("arst_bit_cnt", 32'(bus.bit_cnt), 0);
    chk("arst_sampled_bit", 32'(bus.sampled_bit), 0);
    chk("arst_sample_valid", 32'(bus.sample_valid), 0);
    chk("arst_bit_done", 32'(bus.bit_done), 0);
    rst = 1'b1;
    measure(40, f_bd, f_sv, f_fd, n_bd, max_bit);
    chk("arst_cfg_period", 32'(f_bd), 8);
    bus.enable = 1'b0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
